// File: rtl/mux_sched_pkg.sv
// Shared definitions for the 8-requester round-robin mux scheduler.
package mux_sched_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot3to8(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set req bit searching ptr+1, ptr+2, ... mod 8.
module rr_pick8
  import mux_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] w_pos;

  // Offset N_REQ truncates to 0, so ptr itself is examined last.
  always_comb begin
    any   = 1'b0;
    idx   = '0;
    w_pos = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_pos = ptr + k[SEL_W-1:0];
      if (!any && req[w_pos]) begin
        any = 1'b1;
        idx = w_pos;
      end
    end
  end

endmodule

// File: rtl/mux_8_1_rr_sched.sv
// Round-robin scheduler driving select and one-hot grant for a shared 8:1 mux.
// Optional per-owner grant quantum enabled by defining RR_QUANTUM_EN.
module mux_8_1_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int unsigned QUANTUM = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  if ((QUANTUM < 2) || (QUANTUM > 255) || ((1 << CNT_W) <= QUANTUM)) begin : g_param_check
    $error("mux_8_1_rr_sched: QUANTUM must be 2..255 and fit in CNT_W bits");
  end

  state_t           r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
  logic             r_busy, w_busy_nxt;
  logic             w_any;
  logic [SEL_W-1:0] w_idx;
  logic             w_hold;

  rr_pick8 u_pick (
    .req (req),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

`ifdef RR_QUANTUM_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_others;

  assign w_others = |(req & ~r_gnt);

  // Counter saturates at the last slot; preemption only when someone else waits.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_hold    = req[r_sel];
    if (r_state == IDLE) begin
      w_cnt_nxt = '0;
    end else if (r_cnt == CNT_LAST) begin
      if (w_others) w_hold = 1'b0;
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= w_cnt_nxt;
  end
`else
  assign w_hold = req[r_sel];
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_busy_nxt  = r_busy;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (en && w_any) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = onehot3to8(w_idx);
          w_sel_nxt   = w_idx;
          w_busy_nxt  = 1'b1;
          w_ptr_nxt   = w_idx;
        end
      end
      GRANT: begin
        if (!w_hold) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_busy  <= 1'b0;
      r_ptr   <= SEL_W'(N_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign gnt  = r_gnt;
  assign sel  = r_sel;
  assign busy = r_busy;

endmodule

// File: tb/tb_mux_8_1_rr_sched.sv
// Self-checking bench for mux_8_1_rr_sched: vector table plus round-robin and quantum sequences.
module tb_mux_8_1_rr_sched;

`ifdef RR_QUANTUM_EN
  localparam int unsigned TB_Q = 4;
`else
  localparam int unsigned TB_Q = 16;
`endif

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;

  exp_t sb[$];
  exp_t m_x;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  mux_8_1_rr_sched #(.QUANTUM(TB_Q), .CNT_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .req  (req),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy)
  );

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (gnt,sel,busy packed)", name, act, exp);
  endtask

  task automatic apply(input logic r, input logic e, input logic [7:0] rq,
                       input logic [7:0] eg, input logic [2:0] es, input logic eb,
                       input string tag);
    @(negedge clk);
    rst = r;
    en  = e;
    req = rq;
    sb.push_back('{eg, es, eb, tag});
  endtask

  // Each pushed expectation describes the outputs after the next rising edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      m_x = sb.pop_front();
      check(m_x.tag, {gnt, sel, busy}, {m_x.gnt, m_x.sel, m_x.busy});
      check({m_x.tag, "_inv"},
            {11'd0, (($countones(gnt) <= 1) && ((gnt != 8'h00) == busy) &&
                     (!busy || (gnt == (8'd1 << sel))))},
            12'd1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       tv[$];
    logic [7:0] rq;
    int         owner;
    int         ph;

    // rst, en, req, exp gnt, exp sel, exp busy
    tv.push_back('{1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0});
    for (int i = 0; i < 5; i++) tv.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0});
    tv.push_back('{1'b0, 1'b1, 8'h20, 8'h20, 3'd5, 1'b1});
    tv.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 3'd5, 1'b0});
    tv.push_back('{1'b0, 1'b1, 8'h21, 8'h01, 3'd0, 1'b1});
    tv.push_back('{1'b0, 1'b1, 8'h20, 8'h00, 3'd0, 1'b0});
    tv.push_back('{1'b0, 1'b1, 8'h21, 8'h20, 3'd5, 1'b1});
    tv.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 3'd5, 1'b0});
    tv.push_back('{1'b0, 1'b1, 8'h04, 8'h04, 3'd2, 1'b1});
    tv.push_back('{1'b1, 1'b1, 8'h04, 8'h00, 3'd0, 1'b0});
    tv.push_back('{1'b0, 1'b1, 8'h04, 8'h04, 3'd2, 1'b1});
    tv.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 3'd2, 1'b0});
    for (int i = 0; i < 4; i++) tv.push_back('{1'b0, 1'b0, 8'h10, 8'h00, 3'd2, 1'b0});
    tv.push_back('{1'b0, 1'b1, 8'h10, 8'h10, 3'd4, 1'b1});
    tv.push_back('{1'b0, 1'b0, 8'h10, 8'h10, 3'd4, 1'b1});
    tv.push_back('{1'b0, 1'b0, 8'hFF, 8'h10, 3'd4, 1'b1});
    tv.push_back('{1'b0, 1'b1, 8'hEF, 8'h00, 3'd4, 1'b0});
    tv.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 3'd4, 1'b0});

    foreach (tv[i])
      apply(tv[i].rst, tv[i].en, tv[i].req, tv[i].gnt, tv[i].sel, tv[i].busy,
            $sformatf("vec%0d", i));

    // Full round robin: each owner holds 3 cycles, drops req for 2 edges, one idle gap.
    apply(1'b1, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, "rr_reset");
    for (int t = 0; t < 35; t++) begin
      rq = 8'hFF;
      for (int k = 0; k < 8; k++)
        if ((t == 4 * k + 3) || (t == 4 * k + 4)) rq[k] = 1'b0;
      owner = (t / 4) % 8;
      ph    = t % 4;
      apply(1'b0, 1'b1, rq, (ph < 3) ? (8'd1 << owner) : 8'h00, 3'(owner), (ph < 3),
            $sformatf("rr_t%0d", t));
    end

`ifdef RR_QUANTUM_EN
    apply(1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "q_reset");
    for (int t = 0; t < 30; t++) begin
      ph = t % 10;
      if (ph < 4)       apply(1'b0, 1'b1, 8'h03, 8'h01, 3'd0, 1'b1, $sformatf("q_t%0d", t));
      else if (ph == 4) apply(1'b0, 1'b1, 8'h03, 8'h00, 3'd0, 1'b0, $sformatf("q_t%0d", t));
      else if (ph < 9)  apply(1'b0, 1'b1, 8'h03, 8'h02, 3'd1, 1'b1, $sformatf("q_t%0d", t));
      else              apply(1'b0, 1'b1, 8'h03, 8'h00, 3'd1, 1'b0, $sformatf("q_t%0d", t));
    end
    apply(1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "qs_reset");
    for (int t = 0; t < 12; t++)
      apply(1'b0, 1'b1, 8'h01, 8'h01, 3'd0, 1'b1, $sformatf("qs_t%0d", t));
`endif

    apply(1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "final_idle");
    @(posedge clk);
    #3;
    check("sb_drain", 12'(sb.size()), 12'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
